writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the MP4 RISC-V core: accepts one retiring instruction per handshake and drives the write port of the 32×32 general-purpose register file. It selects the write-back source (ALU result, load data, PC+4 or none). For loads it waits for the data-memory response, then byte/halfword-extracts and sign/zero-extends it. It also exports a pending-load scoreboard for hazard detection and a retired-instruction counter.

## Interface
- MEM_TIMEOUT, 255: maximum cycles spent waiting for mem_rvalid before abandoning a load; legal range 1..65535.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has an instruction to retire.
- in_ready  out  1  stage can accept; combinational, high exactly when state is IDLE.
- wb_sel  in  2  00 ALU, 01 LOAD, 10 PC+4, 11 NONE (no register write).
- rd  in  5  destination register index.
- alu_result  in  32  ALU output; also the load address (bits [1:0] used as byte offset).
- pc  in  32  instruction PC.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other value is treated as LW.
- mem_rvalid  in  1  load response valid; sampled only in WAIT_MEM.
- mem_rdata  in  32  aligned load response word.
- rf_write_enable  out  1  register-file write strobe (registered).
- rf_write_addr  out  5  register-file write index (registered).
- rf_write_data  out  32  register-file write data (registered).
- load_busy  out  1  high while in WAIT_MEM.
- load_rd  out  5  destination of the outstanding load; valid when load_busy is high.
- timeout_err  out  1  one-cycle pulse when a load is abandoned.
- instret  out  32  count of retired instructions; wraps at 2^32.

## Operation
- FSM has two states, IDLE and WAIT_MEM. Reset enters IDLE.
- In IDLE, acceptance (in_valid && in_ready) behaves as follows:
  - wb_sel ALU: data = alu_result.
  - wb_sel PC+4: data = pc + 32'd4, mod 2^32.
  - wb_sel NONE: no write.
  - In all three cases the instruction completes on that edge and the state stays IDLE.
  - wb_sel LOAD: capture rd, funct3 and alu_result[1:0]; clear the wait counter; go to WAIT_MEM.
- In WAIT_MEM, while mem_rvalid is high, the extracted data completes the load and the state returns to IDLE. Extraction uses byte offset b = captured addr[1:0]:
  - LB/LBU: byte mem_rdata[8b+7:8b], sign- or zero-extended.
  - LH/LHU: halfword mem_rdata[16·addr[1]+15:16·addr[1]], sign- or zero-extended; addr[0] is ignored.
  - LW: the full word.
- In WAIT_MEM without mem_rvalid, the counter increments. If the counter equals MEM_TIMEOUT−1:
  - the next state is IDLE and timeout_err pulses;
  - no write occurs and instret is not incremented.
  - If mem_rvalid arrives in that same final cycle, the completion takes priority over the timeout.
- Completion means the following update on the completing edge: rf_write_enable ← (rd≠0 && wb_sel≠NONE), rf_write_addr ← rd, rf_write_data ← data, instret ← instret+1.
  - rd = 0 and NONE still count as retired.
- On every non-completing edge, rf_write_enable ← 0. rf_write_addr and rf_write_data hold their last values.
- Reset may be asserted at any time, including mid-load. It immediately forces:
  - state IDLE, so in_ready = 1 during reset;
  - rf_write_enable 0, rf_write_addr 0, rf_write_data 0;
  - load_busy 0, load_rd 0, timeout_err 0, instret 0.
  - The outstanding load is discarded, and a late mem_rvalid is ignored.

## Timing
- Non-load accepted in cycle N: rf_write_enable is high for exactly cycle N+1, and the register file commits at the end of N+1. Back-to-back non-loads produce one write per cycle.
- Load accepted in cycle N: load_busy and in_ready=0 from N+1. If mem_rvalid first arrives in cycle M ≥ N+1:
  - the write pulse occurs in M+1 and load_busy drops in M+1;
  - in_ready rises in M+1, so the next instruction can be accepted in M+1.
- Timeout: with no mem_rvalid during N+1..N+MEM_TIMEOUT, timeout_err is high in N+MEM_TIMEOUT+1 and the stage is IDLE in that cycle.
- mem_rvalid in IDLE, including in the acceptance cycle of a load, is ignored.
- instret reflects a completion in the same cycle as its write pulse.

## Test plan
- Reset, then ALU retire rd=5, alu_result=0xDEADBEEF in cycle N. Required: cycle N+1 has we=1, addr=5, data=0xDEADBEEF; N+2 has we=0; instret=1.
- LB with addr[1:0]=3 and mem_rdata=0x80123456, rvalid 3 cycles after accept. Required: load_busy and load_rd=rd for 3 cycles, then write data 0xFFFFFF80. LBU on the same data gives 0x00000080; LHU with offset 2 gives 0x00008012.
- PC+4 with pc=0xFFFFFFFC, rd=1. Required: data 0x00000000. rd=0 with ALU wb_sel: we stays 0 but instret increments.
- MEM_TIMEOUT=4, load with no response. Required: timeout_err pulses in cycle N+5, no write, instret unchanged. A repeat run with rvalid in cycle N+4 must complete the load normally with no error.
- Back-to-back: ALU, LOAD (rvalid at N+2), ALU presented continuously. Required: writes in N+1 and N+3, second ALU accepted in N+3 and written in N+4, instret=3.
- Assert reset in WAIT_MEM, then pulse mem_rvalid after release. Required: all outputs 0 during reset, in_ready=1, and no write ever issued for the discarded load.

Source files
------------

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - RISC-V write-back stage: source select, load extraction, load scoreboard, instret
module writeback_stage #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  wb_sel,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc,
  input  logic [2:0]  funct3,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        load_busy,
  output logic [4:0]  load_rd,
  output logic        timeout_err,
  output logic [31:0] instret
);

  localparam logic [1:0]  SEL_ALU   = 2'b00;
  localparam logic [1:0]  SEL_LOAD  = 2'b01;
  localparam logic [1:0]  SEL_PC4   = 2'b10;
  localparam logic [1:0]  SEL_NONE  = 2'b11;
  localparam logic [15:0] LAST_WAIT = 16'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_off;
  logic [15:0] wait_cnt;
  logic        accept;
  logic        complete;
  logic        timeout_hit;
  logic        wr_en_nx;
  logic [4:0]  wr_addr_nx;
  logic [31:0] wr_data_nx;
  logic [31:0] load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (in_valid && wb_sel == SEL_LOAD) state_nx = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid || wait_cnt == LAST_WAIT) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Halfword select ignores addr[0]: misaligned halfwords read the aligned half.
  assign ld_byte = mem_rdata[{cap_off, 3'b000} +: 8];
  assign ld_half = mem_rdata[{cap_off[1], 4'b0000} +: 16];

  always_comb begin
    case (cap_funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    in_ready    = (state == IDLE);
    load_busy   = (state == WAIT_MEM);
    accept      = in_valid && in_ready;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    wr_en_nx    = 1'b0;
    wr_addr_nx  = rd;
    wr_data_nx  = alu_result;
    if (state == IDLE) begin
      if (accept && wb_sel != SEL_LOAD) begin
        complete = 1'b1;
        wr_en_nx = (rd != 5'd0) && (wb_sel != SEL_NONE);
        case (wb_sel)
          SEL_ALU: wr_data_nx = alu_result;
          SEL_PC4: wr_data_nx = pc + 32'd4;
          default: wr_data_nx = alu_result;
        endcase
      end
    end else if (mem_rvalid) begin
      // A response in the final wait cycle still wins over the timeout.
      complete   = 1'b1;
      wr_en_nx   = (load_rd != 5'd0);
      wr_addr_nx = load_rd;
      wr_data_nx = load_data;
    end else if (wait_cnt == LAST_WAIT) begin
      timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= 5'd0;
      rf_write_data   <= 32'd0;
      timeout_err     <= 1'b0;
      instret         <= 32'd0;
      load_rd         <= 5'd0;
      cap_funct3      <= 3'd0;
      cap_off         <= 2'd0;
      wait_cnt        <= 16'd0;
    end else begin
      rf_write_enable <= wr_en_nx;
      timeout_err     <= timeout_hit;
      if (complete) begin
        rf_write_addr <= wr_addr_nx;
        rf_write_data <= wr_data_nx;
        instret       <= instret + 32'd1;
      end
      if (accept && wb_sel == SEL_LOAD) begin
        load_rd    <= rd;
        cap_funct3 <= funct3;
        cap_off    <= alu_result[1:0];
        wait_cnt   <= 16'd0;
      end else if (load_busy && !mem_rvalid) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized self-checking bench for writeback_stage against a behavioural model
module tb_writeback_stage;

  localparam int MEM_TO = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wb_sel;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [2:0]  funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        load_busy;
  logic [4:0]  load_rd;
  logic        timeout_err;
  logic [31:0] instret;

  int          total;
  int          bad;
  logic [31:0] exp_instret;

  writeback_stage #(.MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .rd(rd), .alu_result(alu_result), .pc(pc), .funct3(funct3),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .load_busy(load_busy), .load_rd(load_rd),
    .timeout_err(timeout_err), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    int unsigned o, b, h;
    o = off;
    b = (w >> (8 * o)) % 256;
    h = (w >> (16 * (o / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? (b + 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32768) ? (h + 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Presents one instruction and follows it until it completes or times out.
  // lat = cycle (relative to acceptance) in which mem_rvalid is raised; beyond MEM_TO means never.
  task automatic run_instr(input logic [1:0] sel, input logic [4:0] r, input logic [31:0] a,
                           input logic [31:0] p, input logic [2:0] f3, input int lat, input logic [31:0] w);
    logic        exp_we;
    logic [31:0] exp_d;
    bit          done;
    exp_we = (r != 5'd0) && (sel != 2'b11);
    exp_d  = (sel == 2'b01) ? model_load(f3, a[1:0], w) : (sel == 2'b10) ? p + 32'd4 : a;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL accept_ready: got %b exp 1", in_ready); end
    in_valid = 1'b1; wb_sel = sel; rd = r; alu_result = a; pc = p; funct3 = f3;
    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    step();
    in_valid = 1'b0; wb_sel = 2'($urandom); rd = 5'($urandom); alu_result = $urandom;
    funct3 = 3'($urandom); mem_rvalid = 1'b0;
    if (sel != 2'b01) begin
      exp_instret++;
      total++; if (rf_write_enable !== exp_we) begin bad++; $display("FAIL nl_we: got %b exp %b", rf_write_enable, exp_we); end
      if (exp_we) begin
        total++; if (rf_write_addr !== r) begin bad++; $display("FAIL nl_addr: got %0d exp %0d", rf_write_addr, r); end
        total++; if (rf_write_data !== exp_d) begin bad++; $display("FAIL nl_data: got %h exp %h", rf_write_data, exp_d); end
      end
      total++; if (instret !== exp_instret) begin bad++; $display("FAIL nl_instret: got %0d exp %0d", instret, exp_instret); end
    end else begin
      done = 1'b0;
      for (int k = 1; k <= MEM_TO && !done; k++) begin
        total++; if (load_busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL wait_busy: busy %b ready %b exp 1/0", load_busy, in_ready); end
        total++; if (load_rd !== r) begin bad++; $display("FAIL wait_rd: got %0d exp %0d", load_rd, r); end
        total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL wait_we: got %b exp 0", rf_write_enable); end
        mem_rvalid = (k == lat);
        mem_rdata  = (k == lat) ? w : $urandom;
        step();
        mem_rvalid = 1'b0;
        if (k == lat) begin
          done = 1'b1;
          exp_instret++;
          total++; if (rf_write_enable !== exp_we) begin bad++; $display("FAIL ld_we: got %b exp %b", rf_write_enable, exp_we); end
          if (exp_we) begin
            total++; if (rf_write_addr !== r) begin bad++; $display("FAIL ld_addr: got %0d exp %0d", rf_write_addr, r); end
            total++; if (rf_write_data !== exp_d) begin bad++; $display("FAIL ld_data: got %h exp %h (f3 %0d off %0d)", rf_write_data, exp_d, f3, a[1:0]); end
          end
          total++; if (instret !== exp_instret) begin bad++; $display("FAIL ld_instret: got %0d exp %0d", instret, exp_instret); end
          total++; if (load_busy !== 1'b0 || in_ready !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL ld_done: busy %b ready %b terr %b exp 0/1/0", load_busy, in_ready, timeout_err); end
        end
      end
      if (!done) begin
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err: got %b exp 1", timeout_err); end
        total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL to_we: got %b exp 0", rf_write_enable); end
        total++; if (instret !== exp_instret) begin bad++; $display("FAIL to_instret: got %0d exp %0d", instret, exp_instret); end
        total++; if (load_busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL to_idle: busy %b ready %b exp 0/1", load_busy, in_ready); end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; wb_sel = 2'd0; rd = 5'd0; alu_result = 32'd0; pc = 32'd0;
    funct3 = 3'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    step(); step();
    total++; if (rf_write_enable !== 1'b0 || rf_write_addr !== 5'd0 || rf_write_data !== 32'd0) begin bad++; $display("FAIL rst_rf: we %b addr %0d data %h exp 0", rf_write_enable, rf_write_addr, rf_write_data); end
    total++; if (load_busy !== 1'b0 || load_rd !== 5'd0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rst_ld: busy %b rd %0d terr %b exp 0", load_busy, load_rd, timeout_err); end
    total++; if (instret !== 32'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_misc: instret %0d ready %b exp 0/1", instret, in_ready); end
    reset = 1'b0;
    exp_instret = 32'd0;
    step();
  endtask

  task automatic test_alu();
    run_instr(2'b00, 5'd5, 32'hDEADBEEF, 32'h100, 3'd0, 0, 32'd0);
    total++; if (rf_write_data !== 32'hDEADBEEF || instret !== 32'd1) begin bad++; $display("FAIL alu_first: data %h instret %0d exp deadbeef/1", rf_write_data, instret); end
    step();
    total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL alu_pulse: got %b exp 0", rf_write_enable); end
    run_instr(2'b00, 5'd6, 32'h01234567, 32'h0, 3'd0, 0, 32'd0);
    run_instr(2'b00, 5'd7, 32'h89ABCDEF, 32'h0, 3'd0, 0, 32'd0);
  endtask

  task automatic test_loads();
    run_instr(2'b01, 5'd3, 32'h00001003, 32'h0, 3'b000, 3, 32'h80123456);
    total++; if (rf_write_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb: got %h exp ffffff80", rf_write_data); end
    run_instr(2'b01, 5'd3, 32'h00001003, 32'h0, 3'b100, 2, 32'h80123456);
    total++; if (rf_write_data !== 32'h00000080) begin bad++; $display("FAIL lbu: got %h exp 00000080", rf_write_data); end
    run_instr(2'b01, 5'd4, 32'h00002002, 32'h0, 3'b101, 1, 32'h80123456);
    total++; if (rf_write_data !== 32'h00008012) begin bad++; $display("FAIL lhu: got %h exp 00008012", rf_write_data); end
  endtask

  task automatic test_pc4_rd0();
    run_instr(2'b10, 5'd1, 32'h5555AAAA, 32'hFFFFFFFC, 3'd0, 0, 32'd0);
    total++; if (rf_write_data !== 32'h00000000 || rf_write_enable !== 1'b1) begin bad++; $display("FAIL pc4_wrap: data %h we %b exp 0/1", rf_write_data, rf_write_enable); end
    run_instr(2'b00, 5'd0, 32'h12345678, 32'h0, 3'd0, 0, 32'd0);
    run_instr(2'b11, 5'd9, 32'h12345678, 32'h0, 3'd0, 0, 32'd0);
  endtask

  task automatic test_timeout();
    run_instr(2'b01, 5'd8, 32'h0, 32'h0, 3'b010, 0, 32'hA5A5A5A5);
    step();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_pulse: got %b exp 0", timeout_err); end
    run_instr(2'b01, 5'd8, 32'h0, 32'h0, 3'b010, MEM_TO, 32'hA5A5A5A5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    base = exp_instret;
    in_valid = 1'b1; wb_sel = 2'b00; rd = 5'd7; alu_result = 32'h11111111;
    step();
    total++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd7 || rf_write_data !== 32'h11111111) begin bad++; $display("FAIL b2b_w1: we %b addr %0d data %h", rf_write_enable, rf_write_addr, rf_write_data); end
    wb_sel = 2'b01; rd = 5'd9; alu_result = 32'h00000002; funct3 = 3'b101;
    step();
    total++; if (load_busy !== 1'b1 || in_ready !== 1'b0 || rf_write_enable !== 1'b0) begin bad++; $display("FAIL b2b_wait: busy %b ready %b we %b exp 1/0/0", load_busy, in_ready, rf_write_enable); end
    wb_sel = 2'b00; rd = 5'd10; alu_result = 32'h22222222;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    total++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd9 || rf_write_data !== 32'h0000CAFE) begin bad++; $display("FAIL b2b_w2: we %b addr %0d data %h", rf_write_enable, rf_write_addr, rf_write_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd10 || rf_write_data !== 32'h22222222) begin bad++; $display("FAIL b2b_w3: we %b addr %0d data %h", rf_write_enable, rf_write_addr, rf_write_data); end
    exp_instret = base + 32'd3;
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL b2b_instret: got %0d exp %0d", instret, exp_instret); end
    step();
  endtask

  task automatic test_random();
    logic [2:0] f3s [8];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 60; i++) begin
      run_instr(2'($urandom), 5'($urandom), $urandom, $urandom, f3s[$urandom_range(0, 7)],
                $urandom_range(1, MEM_TO + 2), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        step();
        mem_rvalid = 1'b0;
        total++; if (rf_write_enable !== 1'b0 || instret !== exp_instret) begin bad++; $display("FAIL gap: we %b instret %0d exp 0/%0d", rf_write_enable, instret, exp_instret); end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    in_valid = 1'b1; wb_sel = 2'b01; rd = 5'd12; alu_result = 32'h0; funct3 = 3'b010;
    step();
    in_valid = 1'b0;
    step();
    total++; if (load_busy !== 1'b1) begin bad++; $display("FAIL rml_busy: got %b exp 1", load_busy); end
    #2 reset = 1'b1;
    #1;
    total++; if (rf_write_enable !== 1'b0 || rf_write_addr !== 5'd0 || rf_write_data !== 32'd0) begin bad++; $display("FAIL rml_rf: we %b addr %0d data %h exp 0", rf_write_enable, rf_write_addr, rf_write_data); end
    total++; if (load_busy !== 1'b0 || load_rd !== 5'd0 || timeout_err !== 1'b0 || instret !== 32'd0) begin bad++; $display("FAIL rml_ld: busy %b rd %0d terr %b instret %0d exp 0", load_busy, load_rd, timeout_err, instret); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rml_ready: got %b exp 1", in_ready); end
    step();
    total++; if (in_ready !== 1'b1 || load_busy !== 1'b0) begin bad++; $display("FAIL rml_hold: ready %b busy %b exp 1/0", in_ready, load_busy); end
    reset = 1'b0;
    exp_instret = 32'd0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      step();
      total++; if (rf_write_enable !== 1'b0 || load_busy !== 1'b0 || instret !== 32'd0) begin bad++; $display("FAIL rml_late: we %b busy %b instret %0d exp 0", rf_write_enable, load_busy, instret); end
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_alu();
    test_loads();
    test_pc4_rd0();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
